// File: rtl/seg_extra_encoder.sv
// Encodes stable glyphs on an active-low 7-segment bus back into 2-bit
// state codes (E=00, S=01, dash=11) and presents them over valid/ready.
module seg_extra_encoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 3,
  parameter int unsigned DROP_W        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        seg_in,
  output logic [1:0]        code_out,
  output logic              code_err,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [7:0]       SEG_E     = 8'h86;
  localparam logic [7:0]       SEG_S     = 8'h92;
  localparam logic [7:0]       SEG_DASH  = 8'hBF;
  localparam logic [7:0]       SEG_BLANK = 8'hFF;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {IDLE, PEND} state_t;

  state_t            state, state_n;
  logic [7:0]        seg_q, cand, last;
  logic [CNT_W-1:0]  cnt;
  logic              stable_c, event_c;
  logic [1:0]        enc_code_c;
  logic              enc_err_c;
  logic [1:0]        code_out_n;
  logic              code_err_n, code_valid_n;
  logic [DROP_W-1:0] drop_cnt_n;

  // A pattern fires once when it has been held long enough and differs from
  // the last accepted pattern; blank only re-arms the detector.
  assign stable_c = (cnt == CNT_MAX) && (seg_q == cand) && (cand != last);
  assign event_c  = stable_c && (cand != SEG_BLANK);

  always_comb begin
    enc_code_c = 2'b00;
    enc_err_c  = 1'b0;
    case (cand)
      SEG_E:    enc_code_c = 2'b00;
      SEG_S:    enc_code_c = 2'b01;
      SEG_DASH: enc_code_c = 2'b11;
      default:  enc_err_c  = 1'b1;
    endcase
  end

  // Sampling and stability tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      cand  <= SEG_BLANK;
      last  <= SEG_BLANK;
      cnt   <= '0;
    end else begin
      seg_q <= seg_in;
      if (seg_q != cand) begin
        cand <= seg_q;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (stable_c) last <= cand;
    end
  end

  // Handshake next-state and output values.
  always_comb begin
    state_n    = state;
    code_out_n = code_out;
    code_err_n = code_err;
    drop_cnt_n = drop_cnt;
    case (state)
      IDLE: begin
        if (event_c) begin
          state_n    = PEND;
          code_out_n = enc_code_c;
          code_err_n = enc_err_c;
        end
      end
      PEND: begin
        if (code_ready) begin
          if (event_c) begin
            code_out_n = enc_code_c;
            code_err_n = enc_err_c;
          end else begin
            state_n = IDLE;
          end
        end else if (event_c && (drop_cnt != '1)) begin
          drop_cnt_n = drop_cnt + DROP_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    code_valid_n = (state_n == PEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      code_out   <= 2'b00;
      code_err   <= 1'b0;
      code_valid <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_n;
      code_out   <= code_out_n;
      code_err   <= code_err_n;
      code_valid <= code_valid_n;
      drop_cnt   <= drop_cnt_n;
    end
  end

endmodule

// File: tb/tb_seg_extra_encoder.sv
// Bench for seg_extra_encoder: two builds (STABLE_CYCLES=4/DROP_W=4 and
// STABLE_CYCLES=1/DROP_W=2) on shared stimulus, checked against a history model.
module tb_seg_extra_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] seg_in;
  logic       code_ready;

  logic [1:0] co0, co1;
  logic       ce0, ce1, cv0, cv1;
  logic [3:0] dc0;
  logic [1:0] dc1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg_extra_encoder #(.STABLE_CYCLES(4), .CNT_W(3), .DROP_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in),
    .code_out(co0), .code_err(ce0), .code_valid(cv0),
    .code_ready(code_ready), .drop_cnt(dc0)
  );

  seg_extra_encoder #(.STABLE_CYCLES(1), .CNT_W(1), .DROP_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in),
    .code_out(co1), .code_err(ce1), .code_valid(cv1),
    .code_ready(code_ready), .drop_cnt(dc1)
  );

  // Reference model: recent sample history plus per-build handshake state.
  logic [7:0] hist[$];
  int         sc[2]   = '{4, 1};
  int         dmax[2] = '{15, 3};
  logic [7:0] m_last[2];
  bit         m_pend[2];
  logic [1:0] m_code[2];
  bit         m_err[2];
  int         m_drop[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] glyph_code(input logic [7:0] v);
    case (v)
      8'h92:   return 2'b01;
      8'hBF:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic bit glyph_err(input logic [7:0] v);
    return !(v == 8'h86 || v == 8'h92 || v == 8'hBF);
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < 6; k++) hist.push_back(8'hFF);
    for (int i = 0; i < 2; i++) begin
      m_last[i] = 8'hFF;
      m_pend[i] = 1'b0;
      m_code[i] = 2'b00;
      m_err[i]  = 1'b0;
      m_drop[i] = 0;
    end
  endtask

  // A value is accepted once the last STABLE_CYCLES+1 samples all equal it.
  task automatic model_edge(input logic [7:0] s, input bit rdy);
    for (int i = 0; i < 2; i++) begin
      logic [7:0] v;
      bit all_eq, ev;
      v = hist[hist.size()-1];
      all_eq = 1'b1;
      for (int k = 0; k <= sc[i]; k++)
        if (hist[hist.size()-1-k] != v) all_eq = 1'b0;
      ev = 1'b0;
      if (all_eq && v != m_last[i]) begin
        m_last[i] = v;
        ev = (v != 8'hFF);
      end
      if (!m_pend[i]) begin
        if (ev) begin
          m_pend[i] = 1'b1;
          m_code[i] = glyph_code(v);
          m_err[i]  = glyph_err(v);
        end
      end else if (rdy) begin
        if (ev) begin
          m_code[i] = glyph_code(v);
          m_err[i]  = glyph_err(v);
        end else begin
          m_pend[i] = 1'b0;
        end
      end else if (ev && m_drop[i] < dmax[i]) begin
        m_drop[i]++;
      end
    end
    hist.push_back(s);
    if (hist.size() > 6) void'(hist.pop_front());
  endtask

  task automatic compare_all();
    check("valid0", 32'(cv0), 32'(m_pend[0]));
    check("code0",  32'(co0), 32'(m_code[0]));
    check("err0",   32'(ce0), 32'(m_err[0]));
    check("drop0",  32'(dc0), 32'(m_drop[0]));
    check("valid1", 32'(cv1), 32'(m_pend[1]));
    check("code1",  32'(co1), 32'(m_code[1]));
    check("err1",   32'(ce1), 32'(m_err[1]));
    check("drop1",  32'(dc1), 32'(m_drop[1]));
  endtask

  task automatic step(input logic [7:0] s, input bit rdy);
    seg_in     = s;
    code_ready = rdy;
    @(posedge clk);
    model_edge(s, rdy);
    #1;
    compare_all();
  endtask

  task automatic hold(input logic [7:0] s, input bit rdy, input int n);
    for (int k = 0; k < n; k++) step(s, rdy);
  endtask

  // Assert reset mid-cycle; valid must drop without waiting for an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_async_valid0", 32'(cv0), 32'd0);
    check("rst_async_valid1", 32'(cv1), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_code0", 32'(co0), 32'd0);
    check("rst_err0",  32'(ce0), 32'd0);
    check("rst_drop0", 32'(dc0), 32'd0);
    check("rst_drop1", 32'(dc1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int first0, first1;
    logic [7:0] glyphs[4];
    rst_n      = 1'b1;
    seg_in     = 8'hFF;
    code_ready = 1'b0;
    glyphs     = '{8'h86, 8'h92, 8'hBF, 8'h86};
    #2;
    do_reset();

    // Latency from first sampling edge of a new value.
    first0 = -1;
    first1 = -1;
    for (int k = 0; k < 8; k++) begin
      step(8'h86, 1'b1);
      if (cv0 && first0 < 0) first0 = k;
      if (cv1 && first1 < 0) first1 = k;
    end
    check("latency0", 32'(first0), 32'd5);
    check("latency1", 32'(first1), 32'd2);

    // Sequence of glyphs, blank re-arm, glitch, unknown pattern.
    hold(8'h92, 1'b1, 10);
    hold(8'hBF, 1'b1, 10);
    hold(8'hFF, 1'b1, 10);
    hold(8'hBF, 1'b1, 10);
    hold(8'h86, 1'b1, 10);
    hold(8'h92, 1'b1, 3);
    hold(8'h86, 1'b1, 10);
    hold(8'h00, 1'b1, 6);
    check("unknown_err0",  32'(ce0), 32'd1);
    check("unknown_code0", 32'(co0), 32'd0);
    hold(8'h00, 1'b1, 4);

    // Backpressure: first event held, later ones dropped.
    for (int g = 0; g < 4; g++) hold(glyphs[g], 1'b0, 8);
    check("bp_code0", 32'(co0), 32'd0);
    check("bp_drop0", 32'(dc0), 32'd3);
    check("bp_drop1", 32'(dc1), 32'd3);
    for (int g = 0; g < 20; g++) hold(glyphs[g % 3], 1'b0, 6);
    check("sat_drop0", 32'(dc0), 32'd15);
    check("sat_drop1", 32'(dc1), 32'd3);
    hold(8'hBF, 1'b1, 4);

    // Reset while an event is pending, then blank must stay silent.
    do_reset();
    hold(8'h86, 1'b0, 7);
    check("pend_before_rst", 32'(cv0), 32'd1);
    do_reset();
    hold(8'hFF, 1'b1, 10);

    // Randomised glyph runs with mixed ready behaviour.
    for (int seg = 0; seg < 300; seg++) begin
      logic [7:0] v;
      int len, mode;
      case ($urandom_range(0, 5))
        0: v = 8'h86;
        1: v = 8'h92;
        2: v = 8'hBF;
        3: v = 8'hFF;
        4: v = 8'h00;
        default: v = 8'($urandom);
      endcase
      len  = $urandom_range(1, 9);
      mode = $urandom_range(0, 3);
      for (int k = 0; k < len; k++) begin
        bit r;
        r = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom);
        step(v, r);
      end
      if ($urandom_range(0, 39) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
